mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter with bounded hold and tie-break pointer.
// Grants are combinational; read data returns one cycle after grant.
module mem_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       async_nreset,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       rvalid0,
  output logic       rvalid1,
  output logic [7:0] rdata,
  output logic [7:0] mem_addr_out,
  output logic [7:0] mem_data_out,
  output logic       mem_write,
  input  logic [7:0] mem_data_in
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] HOLD = 4'(MAX_HOLD);

  state_t     state;
  state_t     state_nx;
  logic       ptr;
  logic       ptr_nx;
  logic [3:0] cnt;
  logic [3:0] cnt_nx;
  logic [3:0] cnt_inc;
  logic       hold_ok;
  logic       pick0;

  assign hold_ok = (cnt < HOLD);
  assign cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;

  // Contention winner: owner keeps the bus until its hold runs out.
  always_comb begin
    pick0 = ptr;
    unique case (state)
      OWN0:    pick0 = hold_ok;
      OWN1:    pick0 = !hold_ok;
      default: pick0 = ptr;
    endcase
  end

  // Grant decode from current requests.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (1'b1)
      (req0 && !req1): gnt0 = 1'b1;
      (req1 && !req0): gnt1 = 1'b1;
      (req0 && req1): begin
        gnt0 = pick0;
        gnt1 = !pick0;
      end
      default: ;
    endcase
  end

  // Owner, pointer and hold-count update.
  always_comb begin
    state_nx = IDLE;
    ptr_nx   = ptr;
    cnt_nx   = 4'd0;
    unique case (1'b1)
      gnt0: begin
        state_nx = OWN0;
        ptr_nx   = 1'b0;
        cnt_nx   = (state == OWN0) ? cnt_inc : 4'd1;
      end
      gnt1: begin
        state_nx = OWN1;
        ptr_nx   = 1'b1;
        cnt_nx   = (state == OWN1) ? cnt_inc : 4'd1;
      end
      default: ;
    endcase
  end

  // Memory-side mux of the granted requester.
  always_comb begin
    mem_addr_out = 8'h00;
    mem_data_out = 8'h00;
    mem_write    = 1'b0;
    unique case (1'b1)
      gnt0: begin
        mem_addr_out = addr0;
        mem_data_out = wdata0;
        mem_write    = we0;
      end
      gnt1: begin
        mem_addr_out = addr1;
        mem_data_out = wdata1;
        mem_write    = we1;
      end
      default: ;
    endcase
  end

  assign rdata = (rvalid0 || rvalid1) ? mem_data_in : 8'h00;

  // Arbiter state and read-return flags.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      state   <= IDLE;
      ptr     <= 1'b1;
      cnt     <= 4'd0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      cnt     <= cnt_nx;
      rvalid0 <= gnt0 && !we0;
      rvalid1 <= gnt1 && !we1;
    end
  end

endmodule
